// File: rtl/btn_conditioner.sv
// btn_conditioner
//
// Two-channel push-button conditioner that drives the increment/decrement command inputs of the
// PWM duty-cycle block. Each raw button is synchronised, debounced and turned into single-cycle
// command pulses, so the PWM stage sees one clean pulse per intentional press.
//
// Build option:
//   AUTO_REPEAT_EN  when defined, a held button emits further pulses: the first one REPEAT_DELAY
//                   cycles after the initial pulse, then one every REPEAT_PERIOD cycles. When
//                   undefined, exactly one pulse is emitted per debounced press and the repeat
//                   parameters only contribute to the counter width.
//
// Parameters (all minimum 2):
//   DEBOUNCE_CYCLES  consecutive cycles the synchronised input must differ from the debounced
//                    level before the level flips
//   REPEAT_DELAY     cycles from a pulse to the first auto-repeat pulse
//   REPEAT_PERIOD    cycles between subsequent auto-repeat pulses
//
// Ports:
//   clk_i          system clock, all logic on the rising edge
//   rst_s_ni       synchronous, active-low reset
//   btn_inc_raw_i  raw increment button (asynchronous, active-high)
//   btn_dec_raw_i  raw decrement button (asynchronous, active-high)
//   inc_pulse_o    one-cycle increment command
//   dec_pulse_o    one-cycle decrement command
//   inc_level_o    debounced increment button level
//   dec_level_o    debounced decrement button level
//
// Press latency with N = DEBOUNCE_CYCLES and edge 1 the first edge sampling the raw press:
// level rises at edge N+2, pulse is high for the cycle after edge N+3.
//
// Conflict handling: while both debounced levels are high no pulses are issued and both repeat
// counts are held at zero. A channel whose level rises while the other is already high (or both
// rising together) moves to the held state silently, so releasing one button never produces a
// fresh initial pulse on the other.

module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk_i,
  input  logic rst_s_ni,
  input  logic btn_inc_raw_i,
  input  logic btn_dec_raw_i,
  output logic inc_pulse_o,
  output logic dec_pulse_o,
  output logic inc_level_o,
  output logic dec_level_o
);

  // One counter width shared by the debounce and repeat counters.
  localparam int unsigned MaxRep   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
  localparam int unsigned MaxParam = (DEBOUNCE_CYCLES > MaxRep) ? DEBOUNCE_CYCLES : MaxRep;
  localparam int unsigned CntW     = $clog2(MaxParam) + 1;

  localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);

  // Channel indices into the per-channel vectors.
  localparam int unsigned ChInc = 0;
  localparam int unsigned ChDec = 1;

  // Per-channel FSM encoding.
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StHeld   = 2'd1;
`ifdef AUTO_REPEAT_EN
  localparam logic [1:0] StRepeat = 2'd2;

  localparam logic [CntW-1:0] DelayLast  = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] PeriodLast = CntW'(REPEAT_PERIOD - 1);
`endif

  logic [1:0]      raw;
  logic [1:0]      sync0_q;
  logic [1:0]      sync1_q;
  logic [1:0]      level_q;
  logic [1:0]      level_d;
  logic [1:0]      pulse_q;
  logic [1:0]      pulse_d;
  logic [CntW-1:0] deb_cnt_q [2];
  logic [CntW-1:0] deb_cnt_d [2];
  logic [1:0]      state_q   [2];
  logic [1:0]      state_d   [2];
`ifdef AUTO_REPEAT_EN
  logic [CntW-1:0] rep_cnt_q [2];
  logic [CntW-1:0] rep_cnt_d [2];
`endif
  logic            both_held;

  assign raw       = {btn_dec_raw_i, btn_inc_raw_i};
  assign both_held = &level_q;

  // ---------------------------------------------------------------------------------------------
  // Debounce: the counter measures how long the synchronised input has disagreed with the
  // debounced level; any agreement restarts the measurement.
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    level_d = level_q;
    for (int ch = 0; ch < 2; ch++) begin
      deb_cnt_d[ch] = '0;
      if (sync1_q[ch] != level_q[ch]) begin
        if (deb_cnt_q[ch] == DebLast) begin
          level_d[ch] = sync1_q[ch];
        end else begin
          deb_cnt_d[ch] = deb_cnt_q[ch] + CntW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Per-channel press FSM. Priority: released level, then conflict, then normal sequencing.
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pulse_d = '0;
`ifdef AUTO_REPEAT_EN
    rep_cnt_d = rep_cnt_q;
`endif
    for (int ch = 0; ch < 2; ch++) begin
      if (!level_q[ch]) begin
        state_d[ch] = StIdle;
`ifdef AUTO_REPEAT_EN
        rep_cnt_d[ch] = '0;
`endif
      end else if (both_held) begin
        // Park in HELD with a zero count: a rising level during conflict is absorbed silently,
        // and whichever channel stays held resumes from a clean repeat delay.
        state_d[ch] = StHeld;
`ifdef AUTO_REPEAT_EN
        rep_cnt_d[ch] = '0;
`endif
      end else begin
        case (state_q[ch])
          StIdle: begin
            state_d[ch] = StHeld;
            pulse_d[ch] = 1'b1;
`ifdef AUTO_REPEAT_EN
            rep_cnt_d[ch] = '0;
`endif
          end
`ifdef AUTO_REPEAT_EN
          StHeld: begin
            if (rep_cnt_q[ch] == DelayLast) begin
              state_d[ch]   = StRepeat;
              pulse_d[ch]   = 1'b1;
              rep_cnt_d[ch] = '0;
            end else begin
              rep_cnt_d[ch] = rep_cnt_q[ch] + CntW'(1);
            end
          end
          StRepeat: begin
            if (rep_cnt_q[ch] == PeriodLast) begin
              pulse_d[ch]   = 1'b1;
              rep_cnt_d[ch] = '0;
            end else begin
              rep_cnt_d[ch] = rep_cnt_q[ch] + CntW'(1);
            end
          end
`else
          StHeld: begin
            // One pulse per press; only a release leaves this state.
            state_d[ch] = StHeld;
          end
`endif
          default: begin
            state_d[ch] = StIdle;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_s_ni) begin
      sync0_q   <= '0;
      sync1_q   <= '0;
      level_q   <= '0;
      pulse_q   <= '0;
      deb_cnt_q <= '{default: '0};
      state_q   <= '{default: StIdle};
    end else begin
      sync0_q   <= raw;
      sync1_q   <= sync0_q;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      deb_cnt_q <= deb_cnt_d;
      state_q   <= state_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_s_ni) begin
      rep_cnt_q <= '{default: '0};
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`endif

  assign inc_pulse_o = pulse_q[ChInc];
  assign dec_pulse_o = pulse_q[ChDec];
  assign inc_level_o = level_q[ChInc];
  assign dec_level_o = level_q[ChDec];

`ifndef SYNTHESIS
  // The PWM stage relies on mutually exclusive, single-cycle commands.
  a_pulse_excl: assert property (@(posedge clk_i) disable iff (!rst_s_ni)
                                 !(inc_pulse_o && dec_pulse_o));
  a_inc_narrow: assert property (@(posedge clk_i) disable iff (!rst_s_ni)
                                 inc_pulse_o |=> !inc_pulse_o);
  a_dec_narrow: assert property (@(posedge clk_i) disable iff (!rst_s_ni)
                                 dec_pulse_o |=> !dec_pulse_o);
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8 and a 2-unit clock. A behavioural model predicts levels and pulses from the
// raw button history; directed scenarios add hand-computed edge positions and pulse counts.
module tb_btn_conditioner;

  localparam int Deb       = 4;
  localparam int RepDelay  = 20;
  localparam int RepPeriod = 8;
`ifdef AUTO_REPEAT_EN
  localparam bit AutoRep = 1'b1;
`else
  localparam bit AutoRep = 1'b0;
`endif

  // Hand-computed pulse counts per scenario (initial pulse plus repeats, where enabled).
  localparam int ExpCleanPulses = AutoRep ? 5 : 1;  // edges 7, 27, 35, 43, 51
  localparam int ExpCfRepPulses = AutoRep ? 5 : 1;  // edges 7, 47, 55, 63, 71
  localparam int ExpRstPulses   = AutoRep ? 3 : 1;  // edges 7, 27, 35

  logic clk = 1'b0;
  logic rst_s_n;
  logic btn_inc;
  logic btn_dec;
  logic inc_pulse;
  logic dec_pulse;
  logic inc_level;
  logic dec_level;

  always #1 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(Deb),
    .REPEAT_DELAY   (RepDelay),
    .REPEAT_PERIOD  (RepPeriod)
  ) u_dut (
    .clk_i        (clk),
    .rst_s_ni     (rst_s_n),
    .btn_inc_raw_i(btn_inc),
    .btn_dec_raw_i(btn_dec),
    .inc_pulse_o  (inc_pulse),
    .dec_pulse_o  (dec_pulse),
    .inc_level_o  (inc_level),
    .dec_level_o  (dec_level)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  // Event logs of DUT behaviour, as absolute edge numbers.
  int inc_p_q[$];
  int dec_p_q[$];
  int inc_rise_q[$];
  int dec_rise_q[$];
  int inc_fall_q[$];
  int dec_fall_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Position (relative to base) of the n-th logged event after base; -1 if absent.
  function automatic int nth_after(input int q[$], input int base, input int n);
    int seen = 0;
    foreach (q[i]) begin
      if (q[i] > base) begin
        if (seen == n) return q[i] - base;
        seen++;
      end
    end
    return -1;
  endfunction

  function automatic int count_after(input int q[$], input int base);
    int c = 0;
    foreach (q[i]) if (q[i] > base) c++;
    return c;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Behavioural model. Pulses are derived from the age of the current press: an initial pulse
  // when a press is first seen outside a conflict, then repeats at age REPEAT_DELAY and every
  // REPEAT_PERIOD after that. A conflict pins the age to 0 and suppresses pulses.
  // ---------------------------------------------------------------------------------------------
  bit [1:0] hist0;      // raw sample from the previous edge
  bit [1:0] hist1;      // raw sample from two edges ago (what the debouncer sees)
  bit [1:0] m_lvl;
  bit [1:0] m_pulse;
  bit [1:0] m_started;
  int       m_run [2];
  int       m_age [2];

  function automatic bit repeat_due(input int age);
    if (!AutoRep) return 1'b0;
    if (age == RepDelay) return 1'b1;
    return (age > RepDelay) && ((age - RepDelay) % RepPeriod == 0);
  endfunction

  initial begin
    bit [1:0] raw;
    bit       conflict;
    forever begin
      @(posedge clk);
      edge_n++;
      raw = {btn_dec, btn_inc};
      if (!rst_s_n) begin
        hist0 = '0; hist1 = '0; m_lvl = '0; m_pulse = '0; m_started = '0;
        m_run = '{0, 0}; m_age = '{0, 0};
      end else begin
        conflict = m_lvl[0] && m_lvl[1];
        for (int ch = 0; ch < 2; ch++) begin
          m_pulse[ch] = 1'b0;
          if (!m_lvl[ch]) begin
            m_started[ch] = 1'b0;
            m_age[ch]     = 0;
          end else if (conflict) begin
            m_started[ch] = 1'b1;
            m_age[ch]     = 0;
          end else if (!m_started[ch]) begin
            m_started[ch] = 1'b1;
            m_age[ch]     = 0;
            m_pulse[ch]   = 1'b1;
          end else begin
            m_age[ch]++;
            m_pulse[ch] = repeat_due(m_age[ch]);
          end
          if (hist1[ch] != m_lvl[ch]) begin
            m_run[ch]++;
            if (m_run[ch] == Deb) begin
              m_lvl[ch] = hist1[ch];
              m_run[ch] = 0;
            end
          end else begin
            m_run[ch] = 0;
          end
        end
        hist1 = hist0;
        hist0 = raw;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    bit prev_inc = 1'b0;
    bit prev_dec = 1'b0;
    forever begin
      @(negedge clk);
      chk("inc_level", int'(inc_level), int'(m_lvl[0]));
      chk("dec_level", int'(dec_level), int'(m_lvl[1]));
      chk("inc_pulse", int'(inc_pulse), int'(m_pulse[0]));
      chk("dec_pulse", int'(dec_pulse), int'(m_pulse[1]));
      if (inc_pulse) inc_p_q.push_back(edge_n);
      if (dec_pulse) dec_p_q.push_back(edge_n);
      if (inc_level && !prev_inc) inc_rise_q.push_back(edge_n);
      if (!inc_level && prev_inc) inc_fall_q.push_back(edge_n);
      if (dec_level && !prev_dec) dec_rise_q.push_back(edge_n);
      if (!dec_level && prev_dec) dec_fall_q.push_back(edge_n);
      prev_inc = inc_level;
      prev_dec = dec_level;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------------------------
  initial begin
    int base;
    rst_s_n = 1'b0;
    btn_inc = 1'b0;
    btn_dec = 1'b0;

    // Reset with buttons toggling.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      btn_inc = ~btn_inc;
      btn_dec = ~btn_inc;
    end
    chk("rst_outputs", int'({inc_pulse, dec_pulse, inc_level, dec_level}), 0);
    rst_s_n = 1'b1;
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    cycles(10);

    // Clean press of inc for 50 cycles.
    base = edge_n;
    btn_inc = 1'b1;
    cycles(50);
    btn_inc = 1'b0;
    cycles(30);
    chk("clean_lvl_rise", nth_after(inc_rise_q, base, 0), 6);
    chk("clean_pulse0", nth_after(inc_p_q, base, 0), 7);
    chk("clean_npulse", count_after(inc_p_q, base), ExpCleanPulses);
    chk("clean_lvl_fall", nth_after(inc_fall_q, base, 0), 56);
    chk("clean_dec_quiet", count_after(dec_p_q, base), 0);
`ifdef AUTO_REPEAT_EN
    chk("clean_rep1", nth_after(inc_p_q, base, 1), 27);
    chk("clean_rep2", nth_after(inc_p_q, base, 2), 35);
    chk("clean_rep3", nth_after(inc_p_q, base, 3), 43);
`endif

    // Bounce on dec: toggles every 2 cycles, never stable long enough.
    base = edge_n;
    for (int i = 0; i < 30; i++) begin
      btn_dec = ((i / 2) % 2) == 0;
      @(negedge clk);
    end
    btn_dec = 1'b0;
    cycles(20);
    chk("bounce_no_level", count_after(dec_rise_q, base), 0);
    chk("bounce_no_pulse", count_after(dec_p_q, base), 0);

    // Short dec hold of 12 cycles.
    base = edge_n;
    btn_dec = 1'b1;
    cycles(12);
    btn_dec = 1'b0;
    cycles(30);
    chk("short_npulse", count_after(dec_p_q, base), 1);
    chk("short_pulse0", nth_after(dec_p_q, base, 0), 7);
    chk("short_lvl_rise", nth_after(dec_rise_q, base, 0), 6);
    chk("short_lvl_fall", nth_after(dec_fall_q, base, 0), 18);
    chk("short_inc_quiet", count_after(inc_p_q, base), 0);

    // Conflict: inc held, dec joins for 40 cycles, both released together.
    base = edge_n;
    btn_inc = 1'b1;
    cycles(15);
    btn_dec = 1'b1;
    cycles(40);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    cycles(30);
    chk("conf_inc_npulse", count_after(inc_p_q, base), 1);
    chk("conf_inc_pulse0", nth_after(inc_p_q, base, 0), 7);
    chk("conf_dec_npulse", count_after(dec_p_q, base), 0);
    chk("conf_dec_rise", nth_after(dec_rise_q, base, 0), 21);
    chk("conf_inc_fall", nth_after(inc_fall_q, base, 0), 61);

    // Conflict then release of dec: inc resumes from a fresh repeat delay, no new initial pulse.
    base = edge_n;
    btn_inc = 1'b1;
    cycles(9);
    btn_dec = 1'b1;
    cycles(12);
    btn_dec = 1'b0;
    cycles(49);
    btn_inc = 1'b0;
    cycles(30);
    chk("cfrep_npulse", count_after(inc_p_q, base), ExpCfRepPulses);
    chk("cfrep_dec_quiet", count_after(dec_p_q, base), 0);
`ifdef AUTO_REPEAT_EN
    chk("cfrep_rep1", nth_after(inc_p_q, base, 1), 47);
`endif

    // Simultaneous press of both buttons: no pulses at all.
    base = edge_n;
    btn_inc = 1'b1;
    btn_dec = 1'b1;
    cycles(30);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    cycles(20);
    chk("sim_inc_quiet", count_after(inc_p_q, base), 0);
    chk("sim_dec_quiet", count_after(dec_p_q, base), 0);
    chk("sim_inc_rise", nth_after(inc_rise_q, base, 0), 6);
    chk("sim_dec_rise", nth_after(dec_rise_q, base, 0), 6);

    // Reset while inc is held: a fresh press is seen after reset releases.
    btn_inc = 1'b1;
    cycles(20);
    rst_s_n = 1'b0;
    cycles(2);
    chk("midrst_outputs", int'({inc_pulse, dec_pulse, inc_level, dec_level}), 0);
    rst_s_n = 1'b1;
    base = edge_n;
    cycles(30);
    btn_inc = 1'b0;
    cycles(20);
    chk("midrst_lvl_rise", nth_after(inc_rise_q, base, 0), 6);
    chk("midrst_pulse0", nth_after(inc_p_q, base, 0), 7);
    chk("midrst_npulse", count_after(inc_p_q, base), ExpRstPulses);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
